imem_loader: RTL and testbench

//  Write-side partner of the CPU instruction fetch path: receives a framed byte stream
//  and writes 16-bit instruction words into instruction memory, word 0 upward.

---
 rtl/imem_loader_pkg.sv | 30 +++
 rtl/imem_loader_byte_pair_asm.sv | 30 +++
 rtl/imem_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// State encodings are 4 bits wide to match the CPU-side debug bus.
package imem_loader_pkg;

    localparam int LDR_CSUM_W = 16;
    localparam int LDR_WORD_W = 16;
    localparam int LDR_BYTE_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LEN_H = 4'd1,
        ST_LEN_L = 4'd2,
        ST_DAT_H = 4'd3,
        ST_DAT_L = 4'd4,
        ST_CHK_H = 4'd5,
        ST_CHK_L = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERR   = 4'd8
    } ldr_state_e;

    function automatic logic is_receiving(input ldr_state_e s);
        return (s inside {ST_LEN_H, ST_LEN_L, ST_DAT_H, ST_DAT_L, ST_CHK_H, ST_CHK_L});
    endfunction

    // The second byte of every big-endian field completes a word.
    function automatic logic is_low_byte(input ldr_state_e s);
        return (s inside {ST_LEN_L, ST_DAT_L, ST_CHK_L});
    endfunction

endpackage

// File: rtl/imem_loader_byte_pair_asm.sv
// Big-endian byte pair assembler shared by the length, data and checksum fields.
// The high byte is latched; the word is presented combinationally with the low byte.
module byte_pair_asm
    import imem_loader_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  accept_i,
    input  logic                  low_i,
    input  logic [LDR_BYTE_W-1:0] byte_i,
    output logic [LDR_WORD_W-1:0] word_o,
    output logic                  word_valid_o
);

    logic [LDR_BYTE_W-1:0] hi_q;

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi_q <= '0;
        end else if (accept_i && !low_i) begin
            hi_q <= byte_i;
        end
    end

    always_comb begin
        word_o       = {hi_q, byte_i};
        word_valid_o = accept_i && low_i;
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader that fills instruction memory from word 0 and holds the
// CPU until a complete, checksum-valid program is in place. Updates on negedge clock.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LDR_BYTE_W-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [LDR_WORD_W-1:0] imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [LDR_WORD_W:0] DEPTH_L = (LDR_WORD_W + 1)'(DEPTH);

    ldr_state_e              state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        countInc;
    logic [LDR_CSUM_W-1:0]   sum_q, sum_d;
    logic [LDR_WORD_W-1:0]   len_q, len_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [LDR_WORD_W-1:0]   wdata_q, wdata_d;
    logic                    hold_q, hold_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic                    accept;
    logic [LDR_WORD_W-1:0]   pairWord;
    logic                    pairValid;

    assign accept   = rx_valid && is_receiving(state_q);
    assign countInc = count_q + CNT_W'(1);

    byte_pair_asm u_pair (
        .clock        (clock),
        .reset_n      (reset_n),
        .accept_i     (accept),
        .low_i        (is_low_byte(state_q)),
        .byte_i       (rx_data),
        .word_o       (pairWord),
        .word_valid_o (pairValid)
    );

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            sum_q   <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            len_q   <= len_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // The write strobe is registered at the low-byte edge, so the last word's strobe
    // lands in the first cycle of CHK_H.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sum_d   = sum_q;
        len_d   = len_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        error_d = error_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN_H;
                    count_d = '0;
                    sum_d   = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    hold_d  = 1'b1;
                end
            end
            ST_LEN_H: begin
                if (accept) state_d = ST_LEN_L;
            end
            ST_LEN_L: begin
                if (pairValid) begin
                    len_d = pairWord;
                    if (pairWord == '0 || {1'b0, pairWord} > DEPTH_L) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_DAT_H;
                    end
                end
            end
            ST_DAT_H: begin
                if (accept) state_d = ST_DAT_L;
            end
            ST_DAT_L: begin
                if (pairValid) begin
                    sum_d   = sum_q + pairWord;
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    wdata_d = pairWord;
                    count_d = countInc;
                    if (LDR_WORD_W'(countInc) == len_q) state_d = ST_CHK_H;
                    else                                 state_d = ST_DAT_H;
                end
            end
            ST_CHK_H: begin
                if (accept) state_d = ST_CHK_L;
            end
            ST_CHK_L: begin
                if (pairValid) begin
                    if (pairWord == sum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                        hold_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_ready   = is_receiving(state_q);
        imem_we    = we_q;
        imem_addr  = addr_q;
        imem_wdata = wdata_q;
        cpu_hold   = hold_q;
        done       = done_q;
        error      = error_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives framed byte streams on posedge, checks on posedge
// (the DUT is negedge-clocked) and models the instruction memory it writes into.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    logic [15:0] mem [0:1023];
    int          weCount = 0;
    int          nAsserts = 0;
    int          nFails = 0;

    logic [7:0] frameGood [$] = '{8'h00, 8'h02, 8'h41, 8'h0F, 8'h42, 8'h07, 8'h83, 8'h16};
    logic [7:0] frameBad  [$] = '{8'h00, 8'h02, 8'h41, 8'h0F, 8'h42, 8'h07, 8'h83, 8'h17};
    logic [7:0] frameLen0 [$] = '{8'h00, 8'h00};
    logic [7:0] frameLenBig [$] = '{8'h04, 8'h01};
    logic [7:0] frameOne  [$] = '{8'h00, 8'h01, 8'h29, 8'hC0, 8'h29, 8'hC0};

    always #5 clock = ~clock;

    imem_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    // Instruction memory model; the strobe is one full cycle wide so one posedge sees it.
    always @(posedge clock) begin
        if (imem_we) begin
            mem[imem_addr] = imem_wdata;
            weCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int waits;
        waits = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waits < 16) begin
            @(posedge clock);
            waits++;
        end
        if (!rx_ready) checkOutput("rx_ready_wait", {31'b0, rx_ready}, 32'd1);
        @(posedge clock);
    endtask

    task automatic sendBytes(input logic [7:0] f [$], input bit gaps);
        for (int i = 0; i < f.size(); i++) begin
            applyStimulus(f[i]);
            if (gaps && i < f.size() - 1) begin
                rx_valid = 1'b0;
                @(posedge clock);
                checkOutput("ready_gap", {31'b0, rx_ready}, 32'd1);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clock);
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clock);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rx_ready"},   {31'b0, rx_ready},   32'd0);
        checkOutput({tag, "_imem_we"},    {31'b0, imem_we},    32'd0);
        checkOutput({tag, "_imem_addr"},  {22'b0, imem_addr},  32'd0);
        checkOutput({tag, "_imem_wdata"}, {16'b0, imem_wdata}, 32'd0);
        checkOutput({tag, "_cpu_hold"},   {31'b0, cpu_hold},   32'd1);
        checkOutput({tag, "_done"},       {31'b0, done},       32'd0);
        checkOutput({tag, "_error"},      {31'b0, error},      32'd0);
    endtask

    task automatic checkResult(input string tag, input bit expDone);
        checkOutput({tag, "_done"},     {31'b0, done},     {31'b0, expDone});
        checkOutput({tag, "_error"},    {31'b0, error},    {31'b0, !expDone});
        checkOutput({tag, "_cpu_hold"}, {31'b0, cpu_hold}, {31'b0, !expDone});
        checkOutput({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clock);
        checkResetValues("reset");
        reset_n = 1'b1;
        @(posedge clock);
        checkResetValues("after_release");

        // Good two-word frame
        $display("[TB] good frame");
        weCount = 0;
        pulseStart();
        checkOutput("t1_hold_loading", {31'b0, cpu_hold}, 32'd1);
        checkOutput("t1_ready_len",    {31'b0, rx_ready}, 32'd1);
        sendBytes(frameGood, 1'b0);
        idle(2);
        checkResult("t1", 1'b1);
        checkOutput("t1_mem0", {16'b0, mem[0]}, 32'h410F);
        checkOutput("t1_mem1", {16'b0, mem[1]}, 32'h4207);
        checkOutput("t1_we_count", weCount, 32'd2);

        // Bad checksum
        $display("[TB] bad checksum");
        mem[0] = 16'h0; mem[1] = 16'h0; weCount = 0;
        pulseStart();
        checkOutput("t2_done_cleared", {31'b0, done},     32'd0);
        checkOutput("t2_hold_raised",  {31'b0, cpu_hold}, 32'd1);
        sendBytes(frameBad, 1'b0);
        idle(2);
        checkResult("t2", 1'b0);
        checkOutput("t2_mem0", {16'b0, mem[0]}, 32'h410F);
        checkOutput("t2_mem1", {16'b0, mem[1]}, 32'h4207);
        checkOutput("t2_we_count", weCount, 32'd2);

        // Bad lengths
        $display("[TB] bad lengths");
        weCount = 0;
        pulseStart();
        checkOutput("t3_error_cleared", {31'b0, error}, 32'd0);
        sendBytes(frameLen0, 1'b0);
        idle(2);
        checkResult("t3_len0", 1'b0);
        pulseStart();
        checkOutput("t3_error_cleared2", {31'b0, error}, 32'd0);
        sendBytes(frameLenBig, 1'b0);
        idle(2);
        checkResult("t3_len1025", 1'b0);
        checkOutput("t3_we_count", weCount, 32'd0);

        // Good frame with rx_valid toggling
        $display("[TB] gapped frame");
        mem[0] = 16'h0; mem[1] = 16'h0; weCount = 0;
        pulseStart();
        sendBytes(frameGood, 1'b1);
        idle(2);
        checkResult("t4", 1'b1);
        checkOutput("t4_mem0", {16'b0, mem[0]}, 32'h410F);
        checkOutput("t4_mem1", {16'b0, mem[1]}, 32'h4207);
        checkOutput("t4_we_count", weCount, 32'd2);

        // Reset mid-frame after word 0 is written
        $display("[TB] reset mid-frame");
        mem[0] = 16'h0; weCount = 0;
        pulseStart();
        checkOutput("t5_hold_reload", {31'b0, cpu_hold}, 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(frameGood[i]);
        idle(2);
        checkOutput("t5_mem0_pre", {16'b0, mem[0]}, 32'h410F);
        checkOutput("t5_we_pre", weCount, 32'd1);
        checkOutput("t5_ready_mid", {31'b0, rx_ready}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkResetValues("t5_async");
        @(posedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        weCount = 0;
        pulseStart();
        sendBytes(frameGood, 1'b0);
        idle(2);
        checkResult("t5_reload", 1'b1);
        checkOutput("t5_mem0", {16'b0, mem[0]}, 32'h410F);
        checkOutput("t5_mem1", {16'b0, mem[1]}, 32'h4207);
        checkOutput("t5_we_count", weCount, 32'd2);

        // Reload a one-word program from DONE
        $display("[TB] reload from done");
        weCount = 0;
        pulseStart();
        checkOutput("t6_hold_raised", {31'b0, cpu_hold}, 32'd1);
        checkOutput("t6_done_cleared", {31'b0, done}, 32'd0);
        sendBytes(frameOne, 1'b0);
        idle(2);
        checkResult("t6", 1'b1);
        checkOutput("t6_mem0", {16'b0, mem[0]}, 32'h29C0);
        checkOutput("t6_mem1", {16'b0, mem[1]}, 32'h4207);
        checkOutput("t6_we_count", weCount, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
